// File: rtl/xcv5_bram_memory_wide_if.sv
// Clock bundle type and access bus for xcv5_bram_memory_wide.
// The master drives requests; the memory (slave) returns ready/read data.
package xcv5_bram_pkg;
    typedef struct packed {
        logic clk2x;
        logic ce;
    } iu_clk_type;
endpackage

interface xcv5_bram_memory_wide_if #(
    parameter int DW = 128,
    parameter int AW = 9
);
    logic            clr_req;
    logic            ready;
    logic [AW-1:0]   addr;
    logic            re;
    logic            we;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   din;
    logic [DW-1:0]   dout;
    logic            dout_valid;

    modport master (output clr_req, addr, re, we, be, din,
                    input  ready, dout, dout_valid);
    modport slave  (input  clr_req, addr, re, we, be, din,
                    output ready, dout, dout_valid);
endinterface

// File: rtl/xcv5_bram_memory_wide.sv
// Single-port wide block-RAM with byte-lane writes, clear engine and read-valid pipeline.
// Define BRAM_WRFWD_EN to make same-cycle read/write return the new data (write-first).
module xcv5_bram_memory_wide
    import xcv5_bram_pkg::*;
#(
    parameter int DW         = 128,
    parameter int AW         = 9,
    parameter int RD_LAT     = 2,
    parameter int CLR_ON_RST = 1
) (
    input  iu_clk_type              gclk,
    input  logic                    rst,
    xcv5_bram_memory_wide_if.slave  bus
);
    localparam int NB = DW / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     cnt, cnt_nxt;
    logic              ready_q;
    logic              clr_we;
    logic              wr_en;
    logic              rd_en;
    logic              clk;
    logic [DW-1:0]     mem [2**AW];
    logic [DW-1:0]     rd_data;
    logic [DW-1:0]     rd_q;
    logic [RD_LAT-1:0] vld_pipe;

    assign clk       = gclk.clk2x;
    assign wr_en     = rst & ready_q & bus.we & ~gclk.ce;
    assign rd_en     = rst & ready_q & bus.re;
    assign bus.ready = ready_q;

    // ready is registered so it reads 0 while reset is held, whatever the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ready_q <= (state_nxt == IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                clr_we  = 1'b1;
                cnt_nxt = cnt + AW'(1);
                if (&cnt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr_we && rst) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NB; k++)
                if (bus.be[k]) mem[bus.addr][8*k +: 8] <= bus.din[8*k +: 8];
        end
    end

`ifdef BRAM_WRFWD_EN
    // Bypass: lanes written this cycle come straight from din.
    always_comb begin
        rd_data = mem[bus.addr];
        for (int k = 0; k < NB; k++)
            if (wr_en && bus.be[k]) rd_data[8*k +: 8] = bus.din[8*k +: 8];
    end
`else
    assign rd_data = mem[bus.addr];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_pipe <= '0;
            rd_q     <= '0;
        end else begin
            vld_pipe <= RD_LAT'({vld_pipe, rd_en});
            if (rd_en) rd_q <= rd_data;
        end
    end

    assign bus.dout_valid = vld_pipe[RD_LAT-1];

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign bus.dout = rd_q;
        end else begin : g_lat2
            logic [DW-1:0] out_q;
            always_ff @(posedge clk) begin
                if (!rst)             out_q <= '0;
                else if (vld_pipe[0]) out_q <= rd_q;
            end
            assign bus.dout = out_q;
        end
    endgenerate
endmodule
